// File: rtl/lc4_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc4_mem_pkg
// Description : Shared widths, constants and the fill-pipeline stage record
//               for the LC4 instruction-memory fill responder.
// Revision    : 1.0 - initial release
// ============================================================================
package lc4_mem_pkg;

    localparam int          LC4_WORD_W           = 16;
    localparam logic [15:0] LC4_IMEM_PATTERN     = 16'hAAAA;
    localparam int          LC4_IMEM_LATENCY_DEF = 8;

    typedef struct packed {
        logic                  valid;
        logic [LC4_WORD_W-1:0] addr;
        logic [LC4_WORD_W-1:0] data;
    } lc4_fill_stage_t;

endpackage
`default_nettype wire

// File: rtl/lc4_imem_fill_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : lc4_imem_fill_responder_if
// Description : Fill-port and preload bundle between the LC4 instruction
//               cache (master) and the memory-side fill responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface lc4_imem_fill_responder_if;
    import lc4_mem_pkg::*;

    logic                  gwe;
    logic [LC4_WORD_W-1:0] mem_iaddr;
    logic [LC4_WORD_W-1:0] mem_idata;
    logic [LC4_WORD_W-1:0] mem_itag;
    logic                  mem_ivalid;
    logic                  ld_we;
    logic [LC4_WORD_W-1:0] ld_addr;
    logic [LC4_WORD_W-1:0] ld_data;

    modport master (
        output gwe, mem_iaddr, ld_we, ld_addr, ld_data,
        input  mem_idata, mem_itag, mem_ivalid
    );

    modport slave (
        input  gwe, mem_iaddr, ld_we, ld_addr, ld_data,
        output mem_idata, mem_itag, mem_ivalid
    );

endinterface
`default_nettype wire

// File: rtl/lc4_fill_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : lc4_fill_delay_line
// Description : LATENCY-deep shift register of fill-stage records; holds on
//               en=0, clears synchronously on rst. Stage 0 is the capture flop.
// Revision    : 1.0 - initial release
// ============================================================================
module lc4_fill_delay_line
    import lc4_mem_pkg::*;
#(
    parameter int LATENCY = LC4_IMEM_LATENCY_DEF
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            en,
    input  wire lc4_fill_stage_t d,
    output lc4_fill_stage_t      q
);

    lc4_fill_stage_t r_stage [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else if (en) begin
            r_stage[0] <= d;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/lc4_imem_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : lc4_imem_fill_responder
// Description : Memory-side responder for the LC4 I-cache fill port. Returns
//               the addressed word, tagged with its address, LATENCY enabled
//               cycles after the request. Build option LC4_IMEM_PATTERN_EN
//               replaces the backing store with an address^pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
module lc4_imem_fill_responder
    import lc4_mem_pkg::*;
#(
    parameter int LATENCY   = LC4_IMEM_LATENCY_DEF,
    parameter int ADDR_BITS = 10
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    lc4_imem_fill_responder_if.slave  bus
);

    logic [LC4_WORD_W-1:0] w_rd_word;
    lc4_fill_stage_t       w_stage0;
    lc4_fill_stage_t       w_out;

`ifdef LC4_IMEM_PATTERN_EN
    assign w_rd_word = bus.mem_iaddr ^ LC4_IMEM_PATTERN;

    logic w_unused_ld;
    assign w_unused_ld = ^{bus.ld_we, bus.ld_addr, bus.ld_data};
`else
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [LC4_WORD_W-1:0] r_store [DEPTH];

    // Combinational read feeding the stage-0 flop gives read-before-write
    // on a same-edge collision: the flop samples the old word.
    always_ff @(posedge clk) begin
        if (!rst && bus.ld_we) begin
            r_store[bus.ld_addr[ADDR_BITS-1:0]] <= bus.ld_data;
        end
    end

    assign w_rd_word = r_store[bus.mem_iaddr[ADDR_BITS-1:0]];

    generate
        if (ADDR_BITS < LC4_WORD_W) begin : g_ld_addr_hi
            logic w_unused_ld_hi;
            assign w_unused_ld_hi = ^bus.ld_addr[LC4_WORD_W-1:ADDR_BITS];
        end
    endgenerate
`endif

    always_comb begin
        w_stage0       = '0;
        w_stage0.valid = 1'b1;
        w_stage0.addr  = bus.mem_iaddr;
        w_stage0.data  = w_rd_word;
    end

    lc4_fill_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .en  (bus.gwe),
        .d   (w_stage0),
        .q   (w_out)
    );

    assign bus.mem_idata  = w_out.data;
    assign bus.mem_itag   = w_out.addr;
    assign bus.mem_ivalid = w_out.valid;

endmodule
`default_nettype wire

// File: tb/tb_lc4_imem_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc4_imem_fill_responder
// Description : Directed self-checking bench for lc4_imem_fill_responder
//               (LATENCY=8, ADDR_BITS=10); honours LC4_IMEM_PATTERN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc4_imem_fill_responder;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [15:0] mdl [1024];

    lc4_imem_fill_responder_if bus ();

    lc4_imem_fill_responder #(
        .LATENCY   (8),
        .ADDR_BITS (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [15:0] a);
`ifdef LC4_IMEM_PATTERN_EN
        return a ^ 16'hAAAA;
`else
        return mdl[a[9:0]];
`endif
    endfunction

    // Inputs change after the negedge; outputs are read one negedge after the edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        bus.ld_we   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        tick();
        bus.ld_we   = 1'b0;
        mdl[a[9:0]] = d;
    endtask

    // Issue n requests back-to-back (optional preload on the first edge),
    // then background 0x0000; request i is checked after edge i+8.
    task automatic run_seq(input string nm, input logic [15:0] a [4], input int n,
                           input bit do_ld, input logic [15:0] la, input logic [15:0] ldv);
        logic [15:0] e_data [4];
        for (int t = 1; t <= n + 7; t++) begin
            bus.mem_iaddr = (t <= n) ? a[t-1] : 16'h0000;
            if (t <= n) e_data[t-1] = exp_word(a[t-1]);
            if (t == 1 && do_ld) begin
                bus.ld_we   = 1'b1;
                bus.ld_addr = la;
                bus.ld_data = ldv;
            end
            tick();
            if (t == 1 && do_ld) begin
                bus.ld_we   = 1'b0;
                mdl[la[9:0]] = ldv;
            end
            if (t >= 8) begin
                check_vec($sformatf("%s_data%0d", nm, t - 8), {16'h0, bus.mem_idata}, {16'h0, e_data[t-8]});
                check_vec($sformatf("%s_tag%0d", nm, t - 8), {16'h0, bus.mem_itag}, {16'h0, a[t-8]});
                check_vec($sformatf("%s_valid%0d", nm, t - 8), {31'h0, bus.mem_ivalid}, 32'h1);
            end
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.gwe       = 1'b1;
        bus.mem_iaddr = 16'h0000;
        bus.ld_we     = 1'b0;
        bus.ld_addr   = 16'h0000;
        bus.ld_data   = 16'h0000;
        @(negedge clk);
        tick();
        tick();

        // Preload with the pipeline stalled; the store ignores gwe.
        rst     = 1'b0;
        bus.gwe = 1'b0;
        preload(16'h0000, 16'h1111);
        preload(16'h0001, 16'h2222);
        preload(16'h0002, 16'h3333);
        preload(16'h0010, 16'h1234);
        preload(16'h0020, 16'h0000);
        preload(16'h0005, 16'h5555);

        // 1: reset, then valid rises after the 8th enabled edge
        rst     = 1'b1;
        bus.gwe = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_vec("rst_valid", {31'h0, bus.mem_ivalid}, 32'h0);
        check_vec("rst_data",  {16'h0, bus.mem_idata},  32'h0);
        check_vec("rst_tag",   {16'h0, bus.mem_itag},   32'h0);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_vec($sformatf("warm_valid%0d", e), {31'h0, bus.mem_ivalid}, (e == 8) ? 32'h1 : 32'h0);
            if (e == 7) check_vec("warm_data7", {16'h0, bus.mem_idata}, 32'h0);
        end
        check_vec("warm_data8", {16'h0, bus.mem_idata}, {16'h0, exp_word(16'h0000)});

        // 2: back-to-back requests
        run_seq("seq", '{16'h0000, 16'h0001, 16'h0002, 16'h0000}, 3, 1'b0, 16'h0, 16'h0);

        // 3: direct and aliased lookup
        run_seq("alias", '{16'h0010, 16'h0410, 16'h0000, 16'h0000}, 2, 1'b0, 16'h0, 16'h0);

        // 4: read-before-write collision
        run_seq("coll", '{16'h0020, 16'h0020, 16'h0000, 16'h0000}, 2, 1'b1, 16'h0020, 16'hBEEF);

        // 5: stall mid-flight
        bus.mem_iaddr = 16'h0005;
        tick();
        bus.mem_iaddr = 16'h0000;
        tick();
        tick();
        check_vec("stall_pre_tag", {16'h0, bus.mem_itag}, 32'h0);
        bus.gwe       = 1'b0;
        bus.mem_iaddr = 16'h0005;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_vec($sformatf("stall_tag%0d", s),  {16'h0, bus.mem_itag},  32'h0);
            check_vec($sformatf("stall_data%0d", s), {16'h0, bus.mem_idata}, {16'h0, exp_word(16'h0000)});
        end
        bus.gwe       = 1'b1;
        bus.mem_iaddr = 16'h0000;
        for (int e = 4; e <= 8; e++) begin
            tick();
            if (e == 7) check_vec("stall_early_tag", {16'h0, bus.mem_itag}, 32'h0);
        end
        check_vec("stall_tag",  {16'h0, bus.mem_itag},  32'h0005);
        check_vec("stall_data", {16'h0, bus.mem_idata}, {16'h0, exp_word(16'h0005)});

        // 6: reset mid-flight drops everything in flight
        bus.mem_iaddr = 16'h0010;
        tick();
        bus.mem_iaddr = 16'h0410;
        tick();
        bus.mem_iaddr = 16'h0005;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        bus.mem_iaddr = 16'h0002;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_vec($sformatf("mid_valid%0d", e), {31'h0, bus.mem_ivalid}, (e >= 8) ? 32'h1 : 32'h0);
            check_vec($sformatf("mid_tag%0d", e),   {16'h0, bus.mem_itag},   (e >= 8) ? 32'h0002 : 32'h0);
        end
        check_vec("mid_data", {16'h0, bus.mem_idata}, {16'h0, exp_word(16'h0002)});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
